change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter: TIMEOUT, 15, max cycles coin_req may stay high without coin_ack before a jam is declared (range 1..255).
REQ-002 Ports: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Ports: start  in  1  one-cycle request to begin a payout.
REQ-005 Ports: mode  in  1  sampled with start; 0 = change (credit minus price), 1 = refund (full credit).
REQ-006 Ports: credit  in  4  accumulated coin value in units, sampled with start.
REQ-007 Ports: coffee_price  in  4  drink price in units, sampled with start.
REQ-008 Ports: coin_ack  in  1  hopper acknowledges one coin ejected.
REQ-009 Ports: clear  in  1  synchronous exit from FAULT.
REQ-010 Ports: coin_req  out  1  request hopper to eject one coin.
REQ-011 Ports: coin_denom  out  2  coin to eject: 2'd2 = 5 units, 2'd1 = 2 units, 2'd0 = 1 unit; 2'd3 never driven.
REQ-012 Ports: paid  out  4  value dispensed so far in the current transaction.
REQ-013 Ports: busy  out  1  high in any state other than IDLE.
REQ-014 Ports: done  out  1  one-cycle pulse at successful payout completion.
REQ-015 Ports: error  out  1  one-cycle pulse when change requested with credit < coffee_price.
REQ-016 Ports: jam  out  1  high while in FAULT.

Function
REQ-017 States: IDLE, ISSUE, GAP, DONE, FAULT; all outputs registered.
REQ-018 IDLE + start, mode=0, credit >= coffee_price: remaining <= credit - coffee_price (4-bit, no wrap possible); paid <= 0.
REQ-019 IDLE + start, mode=0, credit < coffee_price: error pulses in the next cycle; state stays IDLE; remaining, paid unchanged; no coin issued.
REQ-020 IDLE + start, mode=1: remaining <= credit; paid <= 0.
REQ-021 Accepted start with remaining nonzero: next state ISSUE, coin_req high in the cycle after start.
REQ-022 Accepted start with remaining zero: next state DONE; done high in the cycle after start; coin_req never asserted.
REQ-023 Denomination: greedy, largest coin <= remaining (5, then 2, then 1); coin_denom loaded on ISSUE entry and held stable while coin_req high.
REQ-024 ISSUE: coin_req held high until coin_ack sampled high; on that edge remaining -= coin value, paid += coin value, coin_req drops.
REQ-025 After ack: remaining nonzero -> GAP for exactly one cycle (coin_req low), then ISSUE; remaining zero -> DONE.
REQ-026 DONE: done high one cycle, then IDLE; paid holds its final value until the next accepted start.
REQ-027 coin_ack while coin_req low is ignored.
REQ-028 Timeout counter clears on ISSUE entry and counts each cycle coin_req is high without ack.
REQ-029 Count reaching TIMEOUT -> FAULT: coin_req low, jam high, remaining and paid frozen.
REQ-030 FAULT exits to IDLE only on clear; start ignored in FAULT.
REQ-031 start ignored whenever busy is high.
REQ-032 Ack on the same edge the count reaches TIMEOUT counts as success; no fault.
REQ-033 At most one coin per ack; paid never exceeds the latched payout amount.

Reset
REQ-034 rst_n low asynchronously forces IDLE; coin_req, busy, done, error, jam = 0; coin_denom = 2'd0; paid = 0; remaining = 0; timeout count = 0.
REQ-035 Reset mid-payout abandons the transaction; no coin_req after rst_n rises until a new accepted start.

Verification
REQ-036 credit=12, price=4, mode=0, ack 2 cycles after each req -> coins 5,2,1; paid=8; single done pulse; req low exactly one cycle between coins.
REQ-037 credit=9, mode=1, ack immediately -> coins 5,2,2; paid=9; done pulse.
REQ-038 credit=4, price=4, mode=0 -> done in the cycle after start; no coin_req; paid=0.
REQ-039 credit=3, price=5, mode=0 -> single error pulse; busy stays 0; no coin_req.
REQ-040 credit=7, mode=1, ack never arrives, TIMEOUT=15 -> jam after 15 cycles with req high; paid=0; start ignored; clear returns to IDLE.
REQ-041 rst_n low during second coin of a 12/4 payout -> all outputs zero immediately; no coin_req after release until a new start.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin-change dispenser: works out a payout (change or full refund) and hands it out
// one coin at a time through a req/ack hopper handshake, largest coin first.
module change_dispenser #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic [3:0] credit,
    input  logic [3:0] coffee_price,
    input  logic       coin_ack,
    input  logic       clear,
    output logic       coin_req,
    output logic [1:0] coin_denom,
    output logic [3:0] paid,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       jam
);

    localparam int unsigned VAL_W = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP,
        DONE,
        FAULT
    } state_t;

    state_t             state;
    logic [VAL_W-1:0]   remaining;
    logic [CNT_W-1:0]   tcount;
    logic [VAL_W-1:0]   payout_c;
    logic [VAL_W-1:0]   coin_value_c;
    logic [CNT_W-1:0]   tcount_next_c;
    logic               short_credit_c;

    // Greedy pick: 5, then 2, then 1.
    function automatic logic [1:0] pick_denom(input logic [VAL_W-1:0] v);
        if (v >= VAL_W'(5))      return 2'd2;
        else if (v >= VAL_W'(2)) return 2'd1;
        else                     return 2'd0;
    endfunction

    function automatic logic [VAL_W-1:0] denom_value(input logic [1:0] d);
        case (d)
            2'd2:    return VAL_W'(5);
            2'd1:    return VAL_W'(2);
            default: return VAL_W'(1);
        endcase
    endfunction

    assign short_credit_c = !mode && (credit < coffee_price);
    assign payout_c       = mode ? credit : VAL_W'(credit - coffee_price);
    assign coin_value_c   = denom_value(coin_denom);
    assign tcount_next_c  = CNT_W'(tcount + CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            remaining  <= '0;
            tcount     <= '0;
            coin_req   <= 1'b0;
            coin_denom <= 2'd0;
            paid       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            jam        <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (short_credit_c) begin
                            error <= 1'b1;
                        end else begin
                            remaining <= payout_c;
                            paid      <= '0;
                            busy      <= 1'b1;
                            if (payout_c == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state      <= ISSUE;
                                coin_req   <= 1'b1;
                                coin_denom <= pick_denom(payout_c);
                                tcount     <= '0;
                            end
                        end
                    end
                end
                // An ack on the timeout edge still wins over the jam.
                ISSUE: begin
                    if (coin_ack) begin
                        remaining <= VAL_W'(remaining - coin_value_c);
                        paid      <= VAL_W'(paid + coin_value_c);
                        coin_req  <= 1'b0;
                        if (remaining == coin_value_c) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        tcount <= tcount_next_c;
                        if (tcount_next_c == CNT_W'(TIMEOUT)) begin
                            state    <= FAULT;
                            coin_req <= 1'b0;
                            jam      <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    state      <= ISSUE;
                    coin_req   <= 1'b1;
                    coin_denom <= pick_denom(remaining);
                    tcount     <= '0;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                FAULT: begin
                    if (clear) begin
                        state <= IDLE;
                        jam   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    coin_req <= 1'b0;
                    busy     <= 1'b0;
                    jam      <= 1'b0;
                end
            endcase
        end
    end

endmodule
